// File: rtl/motion_pkg.sv
// motion_pkg: shared definitions for the tank motion controller.
// Holds the 8-way heading encoding, default screen bounds and start
// position, and the helper that turns per-axis direction signs into a heading.
// Optional feature macro used by the design: MOTION_ACCEL_EN.
package motion_pkg;

    typedef enum logic [2:0] {
        HDG_UP         = 3'd0,
        HDG_UP_RIGHT   = 3'd1,
        HDG_RIGHT      = 3'd2,
        HDG_DOWN_RIGHT = 3'd3,
        HDG_DOWN       = 3'd4,
        HDG_DOWN_LEFT  = 3'd5,
        HDG_LEFT       = 3'd6,
        HDG_UP_LEFT    = 3'd7
    } heading_t;

    localparam logic signed [1:0] DIR_NONE = 2'sb00;
    localparam logic signed [1:0] DIR_POS  = 2'sb01;
    localparam logic signed [1:0] DIR_NEG  = 2'sb11;

    localparam int DEF_X0    = 200;
    localparam int DEF_Y0    = 200;
    localparam int DEF_X_MIN = 3;
    localparam int DEF_X_MAX = 1004;
    localparam int DEF_Y_MIN = 3;
    localparam int DEF_Y_MAX = 744;

    // Screen y grows downwards, so a negative y direction means "up".
    function automatic heading_t encodeHeading(input logic signed [1:0] dirX,
                                               input logic signed [1:0] dirY);
        heading_t hdg;
        hdg = HDG_UP;
        if (dirX == DIR_POS) begin
            if (dirY == DIR_NEG)      hdg = HDG_UP_RIGHT;
            else if (dirY == DIR_POS) hdg = HDG_DOWN_RIGHT;
            else                      hdg = HDG_RIGHT;
        end else if (dirX == DIR_NEG) begin
            if (dirY == DIR_NEG)      hdg = HDG_UP_LEFT;
            else if (dirY == DIR_POS) hdg = HDG_DOWN_LEFT;
            else                      hdg = HDG_LEFT;
        end else if (dirY == DIR_POS) begin
            hdg = HDG_DOWN;
        end else begin
            hdg = HDG_UP;
        end
        return hdg;
    endfunction

endpackage

// File: rtl/motion_axis.sv
// motion_axis: decodes one joystick axis into a signed step and produces the
// clamped next position for that axis. Arithmetic is done two bits wider than
// the position so stepping past 0 or the top of the range never wraps.
module motion_axis
    import motion_pkg::*;
#(
    parameter int AXIS_W    = 10,
    parameter int POS_W     = 12,
    parameter int P_MIN     = DEF_X_MIN,
    parameter int P_MAX     = DEF_X_MAX,
    parameter int DZ_LO     = 400,
    parameter int DZ_HI     = 600,
    parameter int FAST_LO   = 150,
    parameter int FAST_HI   = 850,
    parameter int STEP_SLOW = 1,
    parameter int STEP_FAST = 3
) (
    input  logic [AXIS_W-1:0]       i_sample,
    input  logic [POS_W-1:0]        i_pos,
    input  logic                    i_boost,
    output logic [POS_W-1:0]        o_nextPos,
    output logic signed [1:0]       o_dir
);

    localparam int SW = POS_W + 2;

    localparam logic [AXIS_W-1:0] L_DZ_LO   = AXIS_W'(DZ_LO);
    localparam logic [AXIS_W-1:0] L_DZ_HI   = AXIS_W'(DZ_HI);
    localparam logic [AXIS_W-1:0] L_FAST_LO = AXIS_W'(FAST_LO);
    localparam logic [AXIS_W-1:0] L_FAST_HI = AXIS_W'(FAST_HI);

    localparam logic signed [SW-1:0] L_MIN  = SW'(P_MIN);
    localparam logic signed [SW-1:0] L_MAX  = SW'(P_MAX);
    localparam logic signed [SW-1:0] L_SLOW = SW'(STEP_SLOW);
    localparam logic signed [SW-1:0] L_FAST = SW'(STEP_FAST);

    logic signed [SW-1:0] w_mag;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_clamped;

    // Low samples push the sprite towards larger coordinates, high samples towards smaller.
    always_comb begin
        o_dir = DIR_NONE;
        if (i_sample < L_DZ_LO) begin
            o_dir = DIR_POS;
        end else if (i_sample > L_DZ_HI) begin
            o_dir = DIR_NEG;
        end
    end

    // Step size from the speed zone, optional boost doubling, then add and clamp.
    always_comb begin
        w_mag = ((i_sample < L_FAST_LO) || (i_sample > L_FAST_HI)) ? L_FAST : L_SLOW;
        if (i_boost) begin
            w_mag = w_mag <<< 1;
        end
        w_sum = $signed({2'b00, i_pos});
        if (o_dir == DIR_POS) begin
            w_sum = w_sum + w_mag;
        end else if (o_dir == DIR_NEG) begin
            w_sum = w_sum - w_mag;
        end
        w_clamped = w_sum;
        if (w_sum < L_MIN) begin
            w_clamped = L_MIN;
        end else if (w_sum > L_MAX) begin
            w_clamped = L_MAX;
        end
        o_nextPos = w_clamped[POS_W-1:0];
    end

endmodule

// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: joystick-to-position controller for NCH tanks.
// A shared divider produces a one-cycle movement tick; on each tick every
// channel steps its clamped position and updates its 8-way heading. The video
// timing/RGB bus and enable are delayed by one register stage.
// Optional feature macro: MOTION_ACCEL_EN (hold-to-boost step doubling).
module tank_motion_ctrl
    import motion_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int AXIS_W    = 10,
    parameter int POS_W     = 12,
    parameter int X0        = DEF_X0,
    parameter int Y0        = DEF_Y0,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int DZ_LO     = 400,
    parameter int DZ_HI     = 600,
    parameter int FAST_LO   = 150,
    parameter int FAST_HI   = 850,
    parameter int STEP_SLOW = 1,
    parameter int STEP_FAST = 3,
    parameter int TICK_DIV  = 1000000
`ifdef MOTION_ACCEL_EN
    ,
    parameter int ACCEL_TICKS = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NCH*AXIS_W-1:0]   joy_x,
    input  logic [NCH*AXIS_W-1:0]   joy_y,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    hblnk_in,
    input  logic                    vblnk_in,
    input  logic [11:0]             rgb_in,
    output logic [10:0]             hcount_out,
    output logic [9:0]              vcount_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    hblnk_out,
    output logic                    vblnk_out,
    output logic [11:0]             rgb_out,
    output logic                    enable_out,
    output logic [NCH*POS_W-1:0]    xpos,
    output logic [NCH*POS_W-1:0]    ypos,
    output logic [NCH*3-1:0]        heading,
    output logic [NCH-1:0]          moving,
    output logic                    tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] L_TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] L_X0 = POS_W'(X0);
    localparam logic [POS_W-1:0] L_Y0 = POS_W'(Y0);

    logic [CW-1:0] r_tickCnt;

    // Movement divider; held at zero while the game is not enabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == L_TICK_LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    assign tick = (r_tickCnt == L_TICK_LAST);

    // One-cycle delay of the video bus and enable so downstream drawers stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            enable_out <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_in;
            enable_out <= enable;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [POS_W-1:0]  r_xpos;
        logic [POS_W-1:0]  r_ypos;
        heading_t          r_heading;
        logic              r_moving;
        logic [POS_W-1:0]  w_nextX;
        logic [POS_W-1:0]  w_nextY;
        logic signed [1:0] w_dirX;
        logic signed [1:0] w_dirY;
        logic              w_boost;
        logic              w_moving;
        heading_t          w_hdg;

        motion_axis #(
            .AXIS_W(AXIS_W), .POS_W(POS_W), .P_MIN(X_MIN), .P_MAX(X_MAX),
            .DZ_LO(DZ_LO), .DZ_HI(DZ_HI), .FAST_LO(FAST_LO), .FAST_HI(FAST_HI),
            .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST)
        ) u_axisX (
            .i_sample (joy_x[ch*AXIS_W +: AXIS_W]),
            .i_pos    (r_xpos),
            .i_boost  (w_boost),
            .o_nextPos(w_nextX),
            .o_dir    (w_dirX)
        );

        motion_axis #(
            .AXIS_W(AXIS_W), .POS_W(POS_W), .P_MIN(Y_MIN), .P_MAX(Y_MAX),
            .DZ_LO(DZ_LO), .DZ_HI(DZ_HI), .FAST_LO(FAST_LO), .FAST_HI(FAST_HI),
            .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST)
        ) u_axisY (
            .i_sample (joy_y[ch*AXIS_W +: AXIS_W]),
            .i_pos    (r_ypos),
            .i_boost  (w_boost),
            .o_nextPos(w_nextY),
            .o_dir    (w_dirY)
        );

        assign w_moving = (w_dirX != DIR_NONE) || (w_dirY != DIR_NONE);
        assign w_hdg    = encodeHeading(w_dirX, w_dirY);

`ifdef MOTION_ACCEL_EN
        localparam int HW = $clog2(ACCEL_TICKS + 1);
        logic [HW-1:0] r_hold;

        assign w_boost = (r_hold == HW'(ACCEL_TICKS));

        // Count consecutive ticks held in one direction, saturating at the boost threshold.
        always_ff @(posedge clk) begin
            if (rst || !enable) begin
                r_hold <= '0;
            end else if (tick) begin
                if (w_moving && (w_hdg == r_heading)) begin
                    if (!w_boost) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end else begin
                    r_hold <= '0;
                end
            end
        end
`else
        assign w_boost = 1'b0;
`endif

        // Per-channel position/heading state; disable returns the tank to its start.
        always_ff @(posedge clk) begin
            if (rst || !enable) begin
                r_xpos    <= L_X0;
                r_ypos    <= L_Y0;
                r_heading <= HDG_UP;
                r_moving  <= 1'b0;
            end else if (tick) begin
                r_xpos   <= w_nextX;
                r_ypos   <= w_nextY;
                r_moving <= w_moving;
                if (w_moving) begin
                    r_heading <= w_hdg;
                end
            end
        end

        assign xpos[ch*POS_W +: POS_W] = r_xpos;
        assign ypos[ch*POS_W +: POS_W] = r_ypos;
        assign heading[ch*3 +: 3]      = r_heading;
        assign moving[ch]              = r_moving;
    end

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed self-checking bench for tank_motion_ctrl with
// TICK_DIV = 4 and NCH = 2. With MOTION_ACCEL_EN defined the hold threshold is 2.
module tb_tank_motion_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [19:0] joy_x;
    logic [19:0] joy_y;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic        enable_out;
    logic [23:0] xpos;
    logic [23:0] ypos;
    logic [5:0]  heading;
    logic [1:0]  moving;
    logic        tick;

    int checks = 0;
    int errors = 0;

    tank_motion_ctrl #(
        .NCH(2),
        .TICK_DIV(4)
`ifdef MOTION_ACCEL_EN
        ,
        .ACCEL_TICKS(2)
`endif
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .joy_x(joy_x), .joy_y(joy_y),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
        .enable_out(enable_out),
        .xpos(xpos), .ypos(ypos), .heading(heading), .moving(moving),
        .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int getX(input int ch);
        return int'(xpos[ch*12 +: 12]);
    endfunction

    function automatic int getY(input int ch);
        return int'(ypos[ch*12 +: 12]);
    endfunction

    function automatic int getH(input int ch);
        return int'(heading[ch*3 +: 3]);
    endfunction

    task automatic setJoy(input int ch, input int x, input int y);
        joy_x[ch*10 +: 10] = 10'(x);
        joy_y[ch*10 +: 10] = 10'(y);
    endtask

    task automatic runTicks(input int n);
        for (int t = 0; t < n; t++) begin
            int waitCnt;
            waitCnt = 0;
            while (tick !== 1'b1 && waitCnt < 16) begin
                @(negedge clk);
                waitCnt++;
            end
            if (tick !== 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL tick_timeout: tick=%b required 1", tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic checkPos(input string name, input int ch, input int ex, input int ey);
        checks++;
        if (getX(ch) !== ex || getY(ch) !== ey) begin
            errors++;
            $display("[TB] FAIL %s: ch%0d pos=(%0d,%0d) required (%0d,%0d)",
                     name, ch, getX(ch), getY(ch), ex, ey);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1;
        joy_x = '0; joy_y = '0;
        setJoy(0, 500, 500); setJoy(1, 500, 500);
        hcount_in = 11'd123; vcount_in = 10'd45; hsync_in = 1'b1; vsync_in = 1'b1;
        hblnk_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'hABC;
        repeat (3) @(negedge clk);
        checkPos("reset_pos_ch0", 0, 200, 200);
        checkPos("reset_pos_ch1", 1, 200, 200);
        checks++;
        if (heading !== 6'd0 || moving !== 2'b00 || tick !== 1'b0 || enable_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: heading=%h moving=%b tick=%b enable_out=%b required 0", heading, moving, tick, enable_out);
        end
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 37'd0) begin
            errors++;
            $display("[TB] FAIL reset_video: hcount_out=%0d rgb_out=%h required 0", hcount_out, rgb_out);
        end
        hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL reset_first_tick: cycle %0d tick=%b required %b", k, tick, (k == 3));
            end
        end
        @(negedge clk);
        checkPos("centred_ch0", 0, 200, 200);
        checks++;
        if (heading !== 6'd0 || moving !== 2'b00 || enable_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL centred_state: heading=%h moving=%b enable_out=%b required 0,00,1", heading, moving, enable_out);
        end
    endtask

    task automatic test_slow_diag;
        setJoy(0, 300, 300);
        runTicks(5);
        checkPos("diag_ch0", 0, 205, 205);
        checkPos("diag_ch1_idle", 1, 200, 200);
        checks++;
        if (getH(0) !== 3 || moving !== 2'b01) begin
            errors++;
            $display("[TB] FAIL diag_heading: heading0=%0d moving=%b required 3,01", getH(0), moving);
        end
    endtask

    task automatic test_fast_clamp_min;
        setJoy(0, 500, 500);
        setJoy(1, 900, 500);
        runTicks(65);
        checkPos("fast_ch1_x5", 1, 5, 200);
        checks++;
        if (getH(1) !== 6 || moving !== 2'b10) begin
            errors++;
            $display("[TB] FAIL fast_heading: heading1=%0d moving=%b required 6,10", getH(1), moving);
        end
        runTicks(1);
        checkPos("clamp_min_1", 1, 3, 200);
        runTicks(1);
        checkPos("clamp_min_2", 1, 3, 200);
        checkPos("fast_ch0_still", 0, 205, 205);
    endtask

    task automatic test_clamp_max;
        setJoy(1, 100, 500);
        runTicks(333);
        checkPos("fast_right_1002", 1, 1002, 200);
        setJoy(1, 300, 500);
        runTicks(1);
        checkPos("slow_right_1003", 1, 1003, 200);
        setJoy(1, 100, 500);
        runTicks(1);
        checkPos("clamp_max_1", 1, 1004, 200);
        runTicks(1);
        checkPos("clamp_max_2", 1, 1004, 200);
        checks++;
        if (getH(1) !== 2) begin
            errors++;
            $display("[TB] FAIL right_heading: heading1=%0d required 2", getH(1));
        end
    endtask

    task automatic test_deadzone_edges;
        setJoy(0, 400, 600);
        runTicks(1);
        checkPos("dz_edge_still", 0, 205, 205);
        checks++;
        if (moving[0] !== 1'b0 || getH(0) !== 3) begin
            errors++;
            $display("[TB] FAIL dz_edge_hold: moving0=%b heading0=%0d required 0,3", moving[0], getH(0));
        end
        setJoy(0, 399, 601);
        runTicks(1);
        checkPos("dz_just_out", 0, 206, 204);
        checks++;
        if (moving[0] !== 1'b1 || getH(0) !== 1) begin
            errors++;
            $display("[TB] FAIL upright_heading: moving0=%b heading0=%0d required 1,1", moving[0], getH(0));
        end
        setJoy(0, 150, 850);
        runTicks(1);
        checkPos("fast_edge_slow", 0, 207, 203);
        setJoy(0, 149, 851);
        runTicks(1);
        checkPos("fast_edge_fast", 0, 210, 200);
    endtask

    task automatic test_enable_drop;
        int waitCnt;
        setJoy(0, 100, 100);
        runTicks(10);
        setJoy(0, 100, 500);
        runTicks(3);
        setJoy(0, 300, 500);
        runTicks(1);
        checkPos("pre_drop", 0, 250, 230);
        waitCnt = 0;
        while (tick !== 1'b1 && waitCnt < 16) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (tick !== 1'b1 || enable_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_tick_wait: tick=%b enable_out=%b required 1,1", tick, enable_out);
        end
        enable = 1'b0;
        @(negedge clk);
        checkPos("drop_ch0", 0, 200, 200);
        checkPos("drop_ch1", 1, 200, 200);
        checks++;
        if (heading !== 6'd0 || moving !== 2'b00 || enable_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_state: heading=%h moving=%b enable_out=%b required 0,00,0", heading, moving, enable_out);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL disabled_tick: cycle %0d tick=%b required 0", k, tick);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (tick !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL reenable_tick: cycle %0d tick=%b required %b", k, tick, (k == 3));
            end
        end
        @(negedge clk);
        checkPos("reenable_first", 0, 201, 200);
    endtask

    task automatic test_hold_steps;
        int expX [4];
`ifdef MOTION_ACCEL_EN
        expX = '{202, 203, 205, 207};
`else
        expX = '{202, 203, 204, 205};
`endif
        for (int k = 0; k < 4; k++) begin
            runTicks(1);
            checkPos("hold_step", 0, expX[k], 200);
        end
    endtask

    task automatic test_video;
        logic [36:0] sent;
        for (int k = 0; k < 12; k++) begin
            sent = 37'({$urandom, $urandom});
            {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in} = sent;
            @(negedge clk);
            checks++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== sent) begin
                errors++;
                $display("[TB] FAIL video_delay: out=%h required %h",
                         {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, sent);
            end
        end
    endtask

    task automatic test_reset_mid;
        setJoy(0, 100, 100);
        setJoy(1, 900, 900);
        runTicks(2);
        rst = 1'b1;
        @(negedge clk);
        checkPos("mid_reset_ch0", 0, 200, 200);
        checkPos("mid_reset_ch1", 1, 200, 200);
        checks++;
        if (heading !== 6'd0 || moving !== 2'b00 || tick !== 1'b0 || enable_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: heading=%h moving=%b tick=%b enable_out=%b required 0", heading, moving, tick, enable_out);
        end
        rst = 1'b0;
        runTicks(1);
        checkPos("after_reset_ch1", 1, 197, 197);
    endtask

    initial begin
        test_reset();
        test_slow_diag();
        test_fast_clamp_min();
        test_clamp_max();
        test_deadzone_edges();
        test_enable_drop();
        test_hold_steps();
        test_video();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
